// File: rtl/pbit_request_controller_if.sv
// Request, result and p-bit network signals of the request controller.
// The controller attaches through the slave modport; the request source,
// result consumer and network model attach through the master modport.
interface pbit_request_controller_if #(
  parameter int W = 2
);
  logic           valid_in;
  logic           in_ready;
  logic           MODE;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic [2*W-1:0] op;
  logic [4*W-1:0] net_clamp_mask;
  logic [4*W-1:0] net_clamp_val;
  logic [4*W-1:0] net_state;
  logic           net_state_vld;
  logic [2*W-1:0] res;
  logic           valid_res;
  logic           res_ready;
  logic           timed_out;
  logic           correct;
  logic           busy;

  modport slave (
    input  valid_in, MODE, in1, in2, op, net_state, net_state_vld, res_ready,
    output in_ready, net_clamp_mask, net_clamp_val, res, valid_res,
           timed_out, correct, busy
  );

  modport master (
    output valid_in, MODE, in1, in2, op, net_state, net_state_vld, res_ready,
    input  in_ready, net_clamp_mask, net_clamp_val, res, valid_res,
           timed_out, correct, busy
  );
endinterface

// File: rtl/pbit_request_controller.sv
// Request controller for a W-bit p-bit multiplier/factorizer network.
// Accepts a multiply (clamp in1,in2) or factor (clamp op) request, holds the
// clamps through a settle phase, then watches the network result field until
// it repeats STABLE times or TIMEOUT RUN cycles pass, and presents the result
// with an arithmetic self-check on a valid/ready output.
// The network state is registered once before evaluation, so each RUN cycle's
// sample is judged one clock after it was presented.
module pbit_request_controller #(
  parameter int W       = 2,
  parameter int STABLE  = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  pbit_request_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int SCW = $clog2(STABLE + 1);
  localparam int STW = $clog2(SETTLE + 1);

  logic [1:0]     r_state;
  logic           r_mode;
  logic [W-1:0]   r_in1;
  logic [W-1:0]   r_in2;
  logic [2*W-1:0] r_op;
  logic [STW-1:0] r_settle_cnt;
  logic [CW-1:0]  r_cyc_cnt;
  logic [SCW-1:0] r_stable_cnt;
  logic [2*W-1:0] r_last;
  logic           r_pipe_vld;
  logic [2*W-1:0] r_pipe_field;
  logic [2*W-1:0] r_res;
  logic           r_valid_res;
  logic           r_timed_out;
  logic           r_correct;
  logic           r_busy;
  logic           r_in_ready;
  logic [4*W-1:0] r_mask;
  logic [4*W-1:0] r_val;

  logic           w_match;
  logic [SCW-1:0] w_stable_next;
  logic [2*W-1:0] w_last_next;
  logic           w_stable_hit;
  logic           w_timeout_hit;
  logic [2*W-1:0] w_prod_ops;
  logic [2*W-1:0] w_prod_res;
  logic           w_correct;
  logic [2*W-1:0] w_field;

  assign bus.in_ready       = r_in_ready;
  assign bus.busy           = r_busy;
  assign bus.res            = r_res;
  assign bus.valid_res      = r_valid_res;
  assign bus.timed_out      = r_timed_out;
  assign bus.correct        = r_correct;
  assign bus.net_clamp_mask = r_mask;
  assign bus.net_clamp_val  = r_val;

  // Result field of the live network state for the latched direction:
  // factoring reads {in2,in1}, multiplying reads the product field.
  assign w_field = r_mode ? bus.net_state[2*W-1:0] : bus.net_state[4*W-1:2*W];

  // Stability tracking and self-check for the sample being evaluated this cycle
  always_comb begin
    w_match       = r_pipe_vld && (r_stable_cnt != '0) && (r_pipe_field == r_last);
    w_stable_next = r_stable_cnt;
    w_last_next   = r_last;
    if (r_pipe_vld) begin
      if (w_match) begin
        w_stable_next = r_stable_cnt + SCW'(1);
      end else begin
        w_stable_next = SCW'(1);
        w_last_next   = r_pipe_field;
      end
    end
    w_stable_hit  = r_pipe_vld && (w_stable_next == SCW'(STABLE));
    w_timeout_hit = (r_cyc_cnt == CW'(TIMEOUT));
    w_prod_ops    = {{W{1'b0}}, r_in1} * {{W{1'b0}}, r_in2};
    w_prod_res    = {{W{1'b0}}, w_last_next[W-1:0]} * {{W{1'b0}}, w_last_next[2*W-1:W]};
    w_correct     = r_mode ? (w_prod_res == r_op) : (w_last_next == w_prod_ops);
  end

  // Input register for the network sample; only RUN-phase samples are kept
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pipe_vld   <= 1'b0;
      r_pipe_field <= '0;
    end else begin
      r_pipe_vld   <= (r_state == S_RUN) && bus.net_state_vld;
      r_pipe_field <= w_field;
    end
  end

  // Request FSM: accept, settle, run until stable or timed out, hold result
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_in1        <= '0;
      r_in2        <= '0;
      r_op         <= '0;
      r_settle_cnt <= '0;
      r_cyc_cnt    <= '0;
      r_stable_cnt <= '0;
      r_last       <= '0;
      r_res        <= '0;
      r_valid_res  <= 1'b0;
      r_timed_out  <= 1'b0;
      r_correct    <= 1'b0;
      r_busy       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_mask       <= '0;
      r_val        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (bus.valid_in && r_in_ready) begin
            r_mode       <= bus.MODE;
            r_in1        <= bus.in1;
            r_in2        <= bus.in2;
            r_op         <= bus.op;
            r_settle_cnt <= '0;
            r_timed_out  <= 1'b0;
            r_correct    <= 1'b0;
            r_busy       <= 1'b1;
            r_in_ready   <= 1'b0;
            r_state      <= S_SETTLE;
            if (bus.MODE) begin
              r_mask <= {{(2*W){1'b1}}, {(2*W){1'b0}}};
              r_val  <= {bus.op, {(2*W){1'b0}}};
            end else begin
              r_mask <= {{(2*W){1'b0}}, {(2*W){1'b1}}};
              r_val  <= {{(2*W){1'b0}}, bus.in2, bus.in1};
            end
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == STW'(SETTLE - 1)) begin
            r_cyc_cnt    <= '0;
            r_stable_cnt <= '0;
            r_last       <= '0;
            r_state      <= S_RUN;
          end else begin
            r_settle_cnt <= r_settle_cnt + STW'(1);
          end
        end
        S_RUN: begin
          r_cyc_cnt    <= r_cyc_cnt + CW'(1);
          r_stable_cnt <= w_stable_next;
          r_last       <= w_last_next;
          // Stability takes priority over a coincident timeout.
          if (w_stable_hit || w_timeout_hit) begin
            r_res       <= w_last_next;
            r_timed_out <= !w_stable_hit;
            r_correct   <= w_correct;
            r_valid_res <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: begin
          if (bus.res_ready) begin
            r_valid_res <= 1'b0;
            r_mask      <= '0;
            r_val       <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_request_controller.sv
// Directed bench for pbit_request_controller with W=2, STABLE=4, SETTLE=2,
// TIMEOUT=1024. Expected values are hand computed in the vector table.
module tb_pbit_request_controller;
  localparam int W = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  pbit_request_controller_if #(.W(W)) bus();

  pbit_request_controller #(.W(W), .STABLE(4), .SETTLE(2), .TIMEOUT(1024)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic       mode;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] p;
    logic [7:0] ns;
    logic [3:0] res;
    logic       cor;
    logic [7:0] mask;
    logic [7:0] val;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic mode, input logic [1:0] a, input logic [1:0] b,
                       input logic [3:0] p);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    bus.MODE = mode; bus.in1 = a; bus.in2 = b; bus.op = p;
    bus.valid_in = 1'b1;
    @(posedge CLK); #1;
    bus.valid_in = 1'b0;
  endtask

  // Counts cycles after the accept edge until valid_res; when alt is set the
  // network product field alternates 9 (even cycle after accept) / 8 (odd).
  task automatic wait_result(input bit alt, input int bound, output int lat);
    lat = 0;
    if (alt) bus.net_state = 8'h90;
    while (!bus.valid_res && lat < bound) begin
      @(posedge CLK); #1;
      lat++;
      if (alt) bus.net_state = (lat % 2 == 0) ? 8'h90 : 8'h80;
    end
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(posedge CLK); #1;
    bus.res_ready = 1'b0;
    chk("hs_valid_res", 32'(bus.valid_res), 32'd0);
    chk("hs_mask", 32'(bus.net_clamp_mask), 32'd0);
    chk("hs_val", 32'(bus.net_clamp_val), 32'd0);
    chk("hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_txn(input vec_t v, input bit alt, input int exp_lat, input logic exp_to);
    int lat;
    bus.net_state = v.ns;
    start(v.mode, v.a, v.b, v.p);
    chk("acc_busy", 32'(bus.busy), 32'd1);
    chk("acc_in_ready", 32'(bus.in_ready), 32'd0);
    chk("acc_mask", 32'(bus.net_clamp_mask), 32'(v.mask));
    chk("acc_val", 32'(bus.net_clamp_val), 32'(v.val));
    wait_result(alt, exp_lat + 20, lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("res", 32'(bus.res), 32'(v.res));
    chk("correct", 32'(bus.correct), 32'(v.cor));
    chk("timed_out", 32'(bus.timed_out), 32'(exp_to));
    chk("done_mask", 32'(bus.net_clamp_mask), 32'(v.mask));
    $display("txn mode=%0d in1=%0d in2=%0d op=%0d lat=%0d res=%h correct=%0d timed_out=%0d",
             v.mode, v.a, v.b, v.p, lat, bus.res, bus.correct, bus.timed_out);
    handshake();
  endtask

  initial begin
    vec_t tv;
    int   lat;
    //        mode a     b     p      ns     res    cor   mask   val
    vecs[0] = '{1'b0, 2'd3, 2'd2, 4'd0, 8'h60, 4'h6, 1'b1, 8'h0F, 8'h0B};
    vecs[1] = '{1'b1, 2'd0, 2'd0, 4'd6, 8'h0E, 4'hE, 1'b1, 8'hF0, 8'h60};
    vecs[2] = '{1'b0, 2'd2, 2'd2, 4'd0, 8'h50, 4'h5, 1'b0, 8'h0F, 8'h0A};
    vecs[3] = '{1'b1, 2'd0, 2'd0, 4'd9, 8'h0F, 4'hF, 1'b1, 8'hF0, 8'h90};
    vecs[4] = '{1'b1, 2'd0, 2'd0, 4'd7, 8'h0D, 4'hD, 1'b0, 8'hF0, 8'h70};
    vecs[5] = '{1'b0, 2'd3, 2'd3, 4'd0, 8'h90, 4'h9, 1'b1, 8'h0F, 8'h0F};
    vecs[6] = '{1'b0, 2'd0, 2'd0, 4'd0, 8'h00, 4'h0, 1'b1, 8'h0F, 8'h00};

    bus.valid_in = 1'b0; bus.MODE = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.op = '0;
    bus.net_state = '0; bus.net_state_vld = 1'b1; bus.res_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid_res", 32'(bus.valid_res), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_mask", 32'(bus.net_clamp_mask), 32'd0);
    chk("rst_val", 32'(bus.net_clamp_val), 32'd0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table-driven constant-field transactions
    for (int i = 0; i < 7; i++) do_txn(vecs[i], 1'b0, 7, 1'b0);

    // Timeout: 3x3 with alternating 9/8, last sample is 8
    tv = '{1'b0, 2'd3, 2'd3, 4'd0, 8'h90, 4'h8, 1'b0, 8'h0F, 8'h0F};
    do_txn(tv, 1'b1, 2 + 1024 + 1, 1'b1);

    // Backpressure: result held, no accept until one cycle after handshake
    bus.net_state = 8'h60;
    start(1'b0, 2'd3, 2'd2, 4'd0);
    wait_result(1'b0, 40, lat);
    chk("bp_latency", 32'(lat), 32'd7);
    bus.MODE = 1'b0; bus.in1 = 2'd1; bus.in2 = 2'd1; bus.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("bp_valid_res", 32'(bus.valid_res), 32'd1);
      chk("bp_res", 32'(bus.res), 32'h6);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    $display("txn backpressure held res=%h for 10 cycles", bus.res);
    bus.res_ready = 1'b1;
    @(posedge CLK); #1;
    bus.res_ready = 1'b0;
    chk("bp_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_hs_valid_res", 32'(bus.valid_res), 32'd0);
    bus.net_state = 8'h10;
    @(posedge CLK); #1;
    bus.valid_in = 1'b0;
    chk("bp_acc_busy", 32'(bus.busy), 32'd1);
    chk("bp_acc_val", 32'(bus.net_clamp_val), 32'h05);
    wait_result(1'b0, 40, lat);
    chk("bp2_latency", 32'(lat), 32'd7);
    chk("bp2_res", 32'(bus.res), 32'h1);
    chk("bp2_correct", 32'(bus.correct), 32'd1);
    $display("txn backpressure second mode=0 in1=1 in2=1 lat=%0d res=%h", lat, bus.res);
    handshake();

    // Reset during RUN aborts immediately
    bus.net_state = 8'h60;
    start(1'b0, 2'd3, 2'd2, 4'd0);
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_valid_res", 32'(bus.valid_res), 32'd0);
    chk("abort_mask", 32'(bus.net_clamp_mask), 32'd0);
    chk("abort_val", 32'(bus.net_clamp_val), 32'd0);
    chk("abort_res", 32'(bus.res), 32'd0);
    $display("txn reset during RUN aborted");
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_post_in_ready", 32'(bus.in_ready), 32'd1);
    do_txn(vecs[1], 1'b0, 7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
